// File: rtl/spi_register_bridge_pkg.sv
// Shared widths, register-write record and bridge FSM states for the SPI register bridge.
package spi_register_bridge_pkg;

   localparam int unsigned REG_NUMBER_WIDTH = 16;
   localparam int unsigned REG_VALUE_WIDTH  = 16;
   localparam int unsigned SPI_FRAME_BITS   = 32;
   localparam int unsigned BIT_COUNT_WIDTH  = 6;

   localparam logic [BIT_COUNT_WIDTH-1:0] BIT_COUNT_FULL = BIT_COUNT_WIDTH'(SPI_FRAME_BITS);
   localparam logic [BIT_COUNT_WIDTH-1:0] BIT_COUNT_SAT  = BIT_COUNT_WIDTH'(SPI_FRAME_BITS + 1);

   typedef struct packed {
      logic [REG_NUMBER_WIDTH-1:0] Number;
      logic [REG_VALUE_WIDTH-1:0]  Value;
   } RegisterWrite_t;

   typedef enum logic [1:0] {
      WAIT_DESELECT,
      IDLE,
      SHIFT,
      COMMIT
   } SpiBridgeState_t;

endpackage

// File: rtl/spi_register_bridge_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with registered rise/fall pulses
// derived from the synchronised level.
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Async,
   output logic o_Level,
   output logic o_Rise,
   output logic o_Fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_Async};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign o_Level = sync_q[SYNC_STAGES-1];
   assign o_Rise  = rise_q;
   assign o_Fall  = fall_q;

endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 target: 32-bit frames become single-cycle register writes; MISO echoes
// the last committed frame.
module spi_register_bridge
   import spi_register_bridge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned ERR_COUNT_WIDTH = 8
) (
   input  logic                        i_Clock,
   input  logic                        i_Reset,
   input  logic                        i_SpiSclk,
   input  logic                        i_SpiCsN,
   input  logic                        i_SpiMosi,
   output logic                        o_SpiMiso,
   output logic [REG_NUMBER_WIDTH-1:0] o_RegisterNumber,
   output logic [REG_VALUE_WIDTH-1:0]  o_RegisterValue,
   output logic                        o_RegisterWriteEnable,
   output logic                        o_Busy,
   output logic [ERR_COUNT_WIDTH-1:0]  o_FrameErrorCount
);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (i_SpiSclk),
      .o_Level (sclk_level_unused),
      .o_Rise  (sclk_rise),
      .o_Fall  (sclk_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (i_SpiCsN),
      .o_Level (cs_level),
      .o_Rise  (cs_rise),
      .o_Fall  (cs_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (i_SpiMosi),
      .o_Level (mosi_level),
      .o_Rise  (mosi_rise_unused),
      .o_Fall  (mosi_fall_unused)
   );

   SpiBridgeState_t                  state_q, state_d;
   logic [SPI_FRAME_BITS-1:0]        rx_q, rx_d;
   logic [SPI_FRAME_BITS-1:0]        echo_q, echo_d;
   logic [SPI_FRAME_BITS-1:0]        echo_sh_q, echo_sh_d;
   logic [BIT_COUNT_WIDTH-1:0]       bit_cnt_q, bit_cnt_d;
   logic [ERR_COUNT_WIDTH-1:0]       err_q, err_d;
   RegisterWrite_t                   write_q, write_d;
   logic                             strobe_q, strobe_d;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= WAIT_DESELECT;
         rx_q      <= '0;
         echo_q    <= '0;
         echo_sh_q <= '0;
         bit_cnt_q <= '0;
         err_q     <= '0;
         write_q   <= '0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_q      <= rx_d;
         echo_q    <= echo_d;
         echo_sh_q <= echo_sh_d;
         bit_cnt_q <= bit_cnt_d;
         err_q     <= err_d;
         write_q   <= write_d;
         strobe_q  <= strobe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rx_d      = rx_q;
      echo_d    = echo_q;
      echo_sh_d = echo_sh_q;
      bit_cnt_d = bit_cnt_q;
      err_d     = err_q;
      write_d   = write_q;
      strobe_d  = 1'b0;

      unique case (state_q)
         WAIT_DESELECT: begin
            if (cs_level) state_d = IDLE;
         end
         IDLE: begin
            if (cs_fall) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               echo_sh_d = echo_q;
            end
         end
         SHIFT: begin
            // A CS_N rise swallows any SCLK edge detected in the same cycle.
            if (cs_rise) begin
               if (bit_cnt_q == BIT_COUNT_FULL) begin
                  state_d = COMMIT;
               end else begin
                  state_d = IDLE;
                  if (err_q != '1) err_d = err_q + 1'b1;
               end
            end else begin
               if (sclk_rise) begin
                  rx_d = {rx_q[SPI_FRAME_BITS-2:0], mosi_level};
                  if (bit_cnt_q != BIT_COUNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
               end
               if (sclk_fall) echo_sh_d = {echo_sh_q[SPI_FRAME_BITS-2:0], 1'b0};
            end
         end
         COMMIT: begin
            state_d  = IDLE;
            write_d  = rx_q;
            echo_d   = rx_q;
            strobe_d = 1'b1;
         end
         default: state_d = WAIT_DESELECT;
      endcase
   end

   assign o_SpiMiso             = echo_sh_q[SPI_FRAME_BITS-1] & ~cs_level;
   assign o_RegisterNumber      = write_q.Number;
   assign o_RegisterValue       = write_q.Value;
   assign o_RegisterWriteEnable = strobe_q;
   assign o_Busy                = ~cs_level & ~i_Reset;
   assign o_FrameErrorCount     = err_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Self-checking bench for spi_register_bridge: SPI host driver plus a frame-level
// reference model (last committed word, error count, expected writes).
module tb_spi_register_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk;
   logic        csn;
   logic        mosi;
   logic        miso;
   logic [15:0] reg_num;
   logic [15:0] reg_val;
   logic        reg_we;
   logic        busy;
   logic [7:0]  err_cnt;

   spi_register_bridge #(
      .SYNC_STAGES     (2),
      .ERR_COUNT_WIDTH (8)
   ) dut (
      .i_Clock               (clk),
      .i_Reset               (rst),
      .i_SpiSclk             (sclk),
      .i_SpiCsN              (csn),
      .i_SpiMosi             (mosi),
      .o_SpiMiso             (miso),
      .o_RegisterNumber      (reg_num),
      .o_RegisterValue       (reg_val),
      .o_RegisterWriteEnable (reg_we),
      .o_Busy                (busy),
      .o_FrameErrorCount     (err_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_echo = '0;
   logic [15:0] m_num  = '0;
   logic [15:0] m_val  = '0;
   int          m_err  = 0;
   int          exp_strobes = 0;

   int   strobe_total = 0;
   bit   b2b_seen     = 1'b0;
   logic prev_we      = 1'b0;

   always @(negedge clk) begin
      if (reg_we) strobe_total++;
      if (reg_we && prev_we) b2b_seen = 1'b1;
      prev_we = reg_we;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // rst_bit >= 0 pulses reset just before that bit, with CS still low.
   task automatic send_frame(input logic [31:0] data, input int nbits, input int jit,
                             input int rst_bit, input string tag);
      logic [31:0] echo_exp;
      bit          did_rst;
      bit          exp_commit;
      int          hits;
      int          hit_pos;
      echo_exp = m_echo;
      did_rst  = 1'b0;
      @(negedge clk);
      csn = 1'b0;
      wait_clks(6);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL %s busy_low: got %b expected 1", tag, busy);
      end
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_bit) begin
            rst = 1'b1;
            wait_clks(3);
            rst = 1'b0;
            did_rst = 1'b1;
            m_echo = '0;
            m_num  = '0;
            m_val  = '0;
            m_err  = 0;
            wait_clks(4);
         end
         mosi = (i < 32) ? data[31-i] : 1'($urandom_range(0, 1));
         wait_clks(4 + int'($urandom_range(0, jit)));
         if (i < 32 && !did_rst) begin
            checks++;
            if (miso !== echo_exp[31-i]) begin
               failures++;
               $display("FAIL %s miso_bit%0d: got %b expected %b", tag, i, miso, echo_exp[31-i]);
            end
         end
         sclk = 1'b1;
         wait_clks(4 + int'($urandom_range(0, jit)));
         sclk = 1'b0;
      end
      wait_clks(4 + int'($urandom_range(0, jit)));
      csn = 1'b1;
      hits = 0;
      hit_pos = -1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (reg_we) begin
            hits++;
            hit_pos = c;
         end
      end
      exp_commit = (nbits == 32) && !did_rst;
      if (exp_commit) begin
         m_echo = data;
         m_num  = data[31:16];
         m_val  = data[15:0];
         exp_strobes++;
      end else if (!did_rst) begin
         m_err = (m_err < 255) ? m_err + 1 : 255;
      end
      checks++;
      if (hits != (exp_commit ? 1 : 0)) begin
         failures++;
         $display("FAIL %s strobe_count: got %0d expected %0d", tag, hits, exp_commit ? 1 : 0);
      end
      if (exp_commit) begin
         checks++;
         if (hit_pos != 5) begin
            failures++;
            $display("FAIL %s strobe_latency: got %0d expected 5", tag, hit_pos);
         end
      end
      checks++;
      if (reg_num !== m_num || reg_val !== m_val) begin
         failures++;
         $display("FAIL %s write_data: got %h_%h expected %h_%h", tag, reg_num, reg_val, m_num, m_val);
      end
      checks++;
      if (err_cnt !== 8'(m_err)) begin
         failures++;
         $display("FAIL %s err_count: got %0d expected %0d", tag, err_cnt, m_err);
      end
      checks++;
      if (busy !== 1'b0 || miso !== 1'b0) begin
         failures++;
         $display("FAIL %s deselected_pins: got busy=%b miso=%b expected 0 0", tag, busy, miso);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      csn  = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      wait_clks(4);
      checks++;
      if (busy !== 1'b0 || miso !== 1'b0 || reg_we !== 1'b0) begin
         failures++;
         $display("FAIL reset_in: got busy=%b miso=%b we=%b expected 0 0 0", busy, miso, reg_we);
      end
      rst = 1'b0;
      wait_clks(6);
      checks++;
      if (reg_num !== 16'h0 || reg_val !== 16'h0 || err_cnt !== 8'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_out: got num=%h val=%h err=%0d busy=%b expected 0 0 0 0",
                  reg_num, reg_val, err_cnt, busy);
      end
   endtask

   task automatic test_single_write();
      send_frame(32'h0800_0001, 32, 0, -1, "keyon");
      wait_clks(20);
      checks++;
      if (reg_num !== 16'h0800 || reg_val !== 16'h0001 || err_cnt !== 8'h0) begin
         failures++;
         $display("FAIL keyon_hold: got %h_%h err=%0d expected 0800_0001 err=0", reg_num, reg_val, err_cnt);
      end
   endtask

   task automatic test_echo();
      send_frame(32'h0A00_1234, 32, 0, -1, "echo1");
      send_frame(32'h0A01_0001, 32, 0, -1, "echo2");
      checks++;
      if (reg_num !== 16'h0A01 || reg_val !== 16'h0001) begin
         failures++;
         $display("FAIL echo_final: got %h_%h expected 0A01_0001", reg_num, reg_val);
      end
   endtask

   task automatic test_bad_lengths();
      send_frame($urandom, 31, 0, -1, "len31");
      send_frame($urandom, 33, 0, -1, "len33");
      send_frame($urandom, 0, 0, -1, "len0");
      checks++;
      if (err_cnt !== 8'd3 || reg_num !== 16'h0A01 || reg_val !== 16'h0001) begin
         failures++;
         $display("FAIL bad_len_total: got err=%0d %h_%h expected err=3 0A01_0001", err_cnt, reg_num, reg_val);
      end
   endtask

   task automatic test_reset_midframe();
      send_frame($urandom, 32, 0, 16, "rst_mid");
      send_frame(32'h0800_0000, 32, 0, -1, "after_rst");
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 300; n++) send_frame($urandom, 8, 0, -1, "short8");
      checks++;
      if (err_cnt !== 8'hFF) begin
         failures++;
         $display("FAIL err_saturate: got %0d expected 255", err_cnt);
      end
      send_frame(32'h1000_FFFF, 32, 0, -1, "post_sat");
   endtask

   task automatic test_jitter_random();
      int nb;
      for (int n = 0; n < 80; n++) begin
         nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : 32;
         send_frame($urandom, nb, 3, -1, "jitter");
      end
   endtask

   task automatic test_back_to_back();
      checks++;
      if (b2b_seen !== 1'b0) begin
         failures++;
         $display("FAIL b2b_strobe: got %b expected 0", b2b_seen);
      end
      checks++;
      if (strobe_total != exp_strobes) begin
         failures++;
         $display("FAIL strobe_total: got %0d expected %0d", strobe_total, exp_strobes);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_echo();
      test_bad_lengths();
      test_reset_midframe();
      test_saturation();
      test_jitter_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
